// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller: conversion FSM states,
// active-low 7-segment codes and the binary/BCD dimensions.
package fnd_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int MAX_VAL    = 9999;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  // Segment codes {dp,g,f,e,d,c,b,a}, active-low, dp off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [6:0] seg_lo(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code[6:0];
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: LOAD, 14 SHIFT cycles, DONE, repeating every
// 16 cycles. o_done marks the cycle in which o_bcd holds a finished conversion.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [3:0]       cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = '0;
    case (state_q)
      S_LOAD: begin
        bin_d   = (i_bin > MAX_BIN) ? MAX_BIN : i_bin;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        adj            = dabble_adjust(bcd_q);
        {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_LOAD;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_bcd  = bcd_q;
  assign o_done = (state_q == S_DONE);

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND scanner fed by a continuous binary-to-BCD converter.
// Optional leading-zero blanking is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int DOT_DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] i_data,
  input  logic             i_dot,
  output logic [3:0]       fnd_com,
  output logic [7:0]       fnd_data
);

  localparam int         PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(SCAN_DIV - 1);
  localparam logic [1:0] DOT_IDX = 2'(DOT_DIGIT);

  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .i_bin  (i_data),
    .o_bcd  (conv_bcd),
    .o_done (conv_done)
  );

  logic [PRE_W-1:0]                pre_q, pre_d;
  logic [1:0]                      idx_q, idx_d;
  logic [BCD_DIGITS-1:0][3:0]      digit_q, digit_d;
  logic [3:0]                      com_q, com_d;
  logic [7:0]                      data_q, data_d;
  logic [BCD_DIGITS-1:0]           digit_blank;
  logic [BCD_DIGITS-1:0][6:0]      seg_code;

  genvar gi;

`ifdef FND_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant digit are zero
  logic [BCD_DIGITS-1:1] lead_zero;
  for (gi = 1; gi < BCD_DIGITS; gi++) begin : g_lead
    assign lead_zero[gi] = (digit_q[BCD_DIGITS-1:gi] == '0);
  end
  assign digit_blank = {lead_zero, 1'b0};
`else
  assign digit_blank = '0;
`endif

  for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_seg
    assign seg_code[gi] = digit_blank[gi] ? SEG_BLANK[6:0] : seg_lo(digit_q[gi]);
  end

  always_comb begin
    pre_d   = pre_q + 1'b1;
    idx_d   = idx_q;
    digit_d = digit_q;
    if (pre_q == PRE_TC) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
    if (conv_done) digit_d = conv_bcd;
    com_d  = ~(4'b0001 << idx_q);
    data_d = {~(i_dot && (idx_q == DOT_IDX)), seg_code[idx_q]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      digit_q <= '0;
      com_q   <= 4'b1111;
      data_q  <= SEG_BLANK;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      com_q   <= com_d;
      data_q  <= data_d;
    end
  end

  assign fnd_com  = com_q;
  assign fnd_data = data_q;

endmodule
